hazard_stall_ctrl: RTL

//  Pipeline hazard controller, sited beside the forwarding unit in the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/hazard_stall_ctrl_if.sv | 54 +++++
 rtl/hazard_stall_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Groups the signals between the pipeline and the hazard/stall controller.
//   master : pipeline side; drives ID/EX hazard inputs, receives stall,
//            bubble, flush and mul/div controls plus the perf counters.
//   slave  : controller side; the reverse directions.
// Signals:
//   id_rs1, id_rs2   ID-stage source registers (ADDRESS_W bits)
//   id_use1, id_use2 ID instruction really reads rs1 / rs2
//   ex_valid, ex_rd, ex_mem_read, ex_is_muldiv, ex_br_taken  EX-stage info
//   pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble,
//   ifid_flush, idex_flush, mdu_start, mdu_done               controls
//   stall_cnt, flush_cnt  saturating perf counters (PERF_W bits)
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
  parameter int ADDRESS_W = 5,
  parameter int PERF_W    = 16
);
  logic [ADDRESS_W-1:0] id_rs1;
  logic [ADDRESS_W-1:0] id_rs2;
  logic                 id_use1;
  logic                 id_use2;
  logic                 ex_valid;
  logic [ADDRESS_W-1:0] ex_rd;
  logic                 ex_mem_read;
  logic                 ex_is_muldiv;
  logic                 ex_br_taken;

  logic                 pc_stall;
  logic                 ifid_stall;
  logic                 idex_stall;
  logic                 idex_bubble;
  logic                 exmem_bubble;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 mdu_start;
  logic                 mdu_done;
  logic [PERF_W-1:0]    stall_cnt;
  logic [PERF_W-1:0]    flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use1, id_use2, ex_valid, ex_rd,
           ex_mem_read, ex_is_muldiv, ex_br_taken,
    input  pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble,
           ifid_flush, idex_flush, mdu_start, mdu_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2, ex_valid, ex_rd,
           ex_mem_read, ex_is_muldiv, ex_br_taken,
    output pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble,
           ifid_flush, idex_flush, mdu_start, mdu_done, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline hazard controller for the 5-stage core. Detects load-use hazards,
// sequences multi-cycle mul/div occupancy of EX, and issues taken-branch
// flushes. Controls are combinational from state and inputs.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; forces all controls to 0
//   bus    hazard_stall_ctrl_if.slave (hazard inputs, controls, counters)
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int ADDRESS_W = 5,
  parameter int MD_LAT    = 4,
  parameter int PERF_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);

  localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  logic md_hit, lu_hit, br_hit;
  logic pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble;
  logic ifid_flush, idex_flush, mdu_start, mdu_done;

  assign md_hit = bus.ex_valid & bus.ex_is_muldiv;
  assign br_hit = bus.ex_valid & bus.ex_br_taken;
  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign lu_hit = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != '0) &
                  ((bus.id_use1 & (bus.id_rs1 == bus.ex_rd)) |
                   (bus.id_use2 & (bus.id_rs2 == bus.ex_rd)));

  // Next-state and control decode. The start cycle counts as the first
  // stall cycle, so MD_BUSY runs MD_LAT-1 cycles (cnt from MD_LAT-2 to 0).
  // MD_DONE ignores md_hit because EX still holds the finishing mul/div.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    mdu_start    = 1'b0;
    mdu_done     = 1'b0;

    case (state_q)
      RUN: begin
        if (md_hit) begin
          mdu_start    = 1'b1;
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idex_stall   = 1'b1;
          exmem_bubble = 1'b1;
          cnt_d        = CNT_W'(MD_LAT - 2);
          state_d      = MD_BUSY;
        end else if (br_hit) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu_hit) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      MD_BUSY: begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_bubble = 1'b1;
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        mdu_done = 1'b1;
        state_d  = RUN;
        if (br_hit) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu_hit) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst_n) begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      idex_stall   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      mdu_start    = 1'b0;
      mdu_done     = 1'b0;
    end
  end

  // Perf counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.ifid_stall   = ifid_stall;
  assign bus.idex_stall   = idex_stall;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.mdu_start    = mdu_start;
  assign bus.mdu_done     = mdu_done;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
